// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse receiver.
//   state_t      FSM state encodings
//   DASH_MIN, CHAR_GAP, WORD_GAP, MARK_MAX  timing thresholds in Morse units
//   ASCII_SP, ASCII_Q                       space and '?' characters
//   morse_decode {len,pat} -> ASCII + unknown flag (ITU A-Z, 0-9)
// Pattern convention: first symbol in bit len-1, latest symbol in bit 0,
// 1 = dash, unused upper bits zero.
package morse_pkg;

  typedef enum logic [2:0] {IDLE, MARK, SPACE, EMIT, GAP, ERRW} state_t;

  localparam int DASH_MIN = 2;
  localparam int CHAR_GAP = 2;
  localparam int WORD_GAP = 5;
  localparam int MARK_MAX = 7;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_Q  = 8'h3F;

  typedef struct packed {
    logic       unk;
    logic [7:0] ch;
  } dec_t;

  function automatic dec_t morse_decode(input logic [2:0] len, input logic [7:0] pat);
    dec_t d;
    d.unk = 1'b0;
    d.ch  = ASCII_Q;
    case ({len, pat})
      {3'd2, 8'b01}:    d.ch = "A";
      {3'd4, 8'b1000}:  d.ch = "B";
      {3'd4, 8'b1010}:  d.ch = "C";
      {3'd3, 8'b100}:   d.ch = "D";
      {3'd1, 8'b0}:     d.ch = "E";
      {3'd4, 8'b0010}:  d.ch = "F";
      {3'd3, 8'b110}:   d.ch = "G";
      {3'd4, 8'b0000}:  d.ch = "H";
      {3'd2, 8'b00}:    d.ch = "I";
      {3'd4, 8'b0111}:  d.ch = "J";
      {3'd3, 8'b101}:   d.ch = "K";
      {3'd4, 8'b0100}:  d.ch = "L";
      {3'd2, 8'b11}:    d.ch = "M";
      {3'd2, 8'b10}:    d.ch = "N";
      {3'd3, 8'b111}:   d.ch = "O";
      {3'd4, 8'b0110}:  d.ch = "P";
      {3'd4, 8'b1101}:  d.ch = "Q";
      {3'd3, 8'b010}:   d.ch = "R";
      {3'd3, 8'b000}:   d.ch = "S";
      {3'd1, 8'b1}:     d.ch = "T";
      {3'd3, 8'b001}:   d.ch = "U";
      {3'd4, 8'b0001}:  d.ch = "V";
      {3'd3, 8'b011}:   d.ch = "W";
      {3'd4, 8'b1001}:  d.ch = "X";
      {3'd4, 8'b1011}:  d.ch = "Y";
      {3'd4, 8'b1100}:  d.ch = "Z";
      {3'd5, 8'b11111}: d.ch = "0";
      {3'd5, 8'b01111}: d.ch = "1";
      {3'd5, 8'b00111}: d.ch = "2";
      {3'd5, 8'b00011}: d.ch = "3";
      {3'd5, 8'b00001}: d.ch = "4";
      {3'd5, 8'b00000}: d.ch = "5";
      {3'd5, 8'b10000}: d.ch = "6";
      {3'd5, 8'b11000}: d.ch = "7";
      {3'd5, 8'b11100}: d.ch = "8";
      {3'd5, 8'b11110}: d.ch = "9";
      default:          d.unk = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// morse_debounce: 2-FF synchronizer followed by a stability counter.
//   clk, rst  clock, async active-high reset
//   din       raw asynchronous input
//   dout      clean level; follows din once the synchronized value has
//             differed from dout for DEBOUNCE_CYCLES consecutive cycles
// Reset level is 1 (released, for an active-low button).
module morse_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic [DW-1:0] dcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      dout <= 1'b1;
      dcnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/morse_rx.sv
// morse_rx: Morse key receiver, decodes button presses to ASCII.
//   clk, rst    clock, async active-high reset
//   key_n       raw active-low button (asynchronous)
//   char_data   decoded character, held until accepted
//   char_valid  char_data valid
//   char_ready  consumer accepts on char_valid && char_ready
//   err         1-cycle pulse: unknown pattern, symbol overflow, over-long mark
//   overrun     1-cycle pulse: character dropped because output was full
//   led_echo_n  active-low echo of the debounced key (only with MORSE_RX_ECHO_EN)
// cnt holds the number of completed cycles the debounced key has spent at
// its current level (reloaded to 1 on each edge).  In an edge cycle it
// therefore reads the full length of the level just ended.  Gap and
// long-mark thresholds fire in the cycle that completes the interval
// (cnt == N*DOT-1), so an edge arriving in that same cycle wins and one
// arriving just after a full interval is too late.
module morse_rx
  import morse_pkg::*;
#(
  parameter int DOT_CYCLES      = 4800000,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int MAX_SYMBOLS     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       err,
  output logic       overrun
`ifdef MORSE_RX_ECHO_EN
  ,
  output logic       led_echo_n
`endif
);
  localparam int CW = $clog2(8 * DOT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(8 * DOT_CYCLES);
  localparam logic [CW-1:0] T_DASH  = CW'(DASH_MIN * DOT_CYCLES);
  localparam logic [CW-1:0] T_CHAR  = CW'(CHAR_GAP * DOT_CYCLES - 1);
  localparam logic [CW-1:0] T_WORD  = CW'(WORD_GAP * DOT_CYCLES - 1);
  localparam logic [CW-1:0] T_MARK  = CW'(MARK_MAX * DOT_CYCLES - 1);

  logic                   key_clean_n, key, key_d, press, rel;
  logic [CW-1:0]          cnt;
  state_t                 state;
  logic [2:0]             len;
  logic [MAX_SYMBOLS-1:0] pat;
  logic                   push_r;
  logic [7:0]             push_dat;
  dec_t                   dec;

  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (key_n),
    .dout (key_clean_n)
  );

  assign key   = ~key_clean_n;
  assign press = key & ~key_d;
  assign rel   = ~key & key_d;
  assign dec   = morse_decode(len, 8'(pat));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_d <= 1'b0;
      cnt   <= '0;
    end else begin
      key_d <= key;
      if (press || rel)        cnt <= CW'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  // FSM + symbol register; pushes are registered and consumed by the
  // output register one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      pat      <= '0;
      err      <= 1'b0;
      push_r   <= 1'b0;
      push_dat <= '0;
    end else begin
      err    <= 1'b0;
      push_r <= 1'b0;
      case (state)
        IDLE: if (press) state <= MARK;
        MARK: begin
          if (rel) begin
            if (len == 3'(MAX_SYMBOLS)) begin
              err   <= 1'b1;
              len   <= '0;
              pat   <= '0;
              state <= ERRW;
            end else begin
              len   <= len + 3'd1;
              pat   <= {pat[MAX_SYMBOLS-2:0], (cnt >= T_DASH)};
              state <= SPACE;
            end
          end else if (cnt == T_MARK) begin
            err   <= 1'b1;
            len   <= '0;
            pat   <= '0;
            state <= ERRW;
          end
        end
        SPACE: begin
          if (press)              state <= MARK;
          else if (cnt == T_CHAR) state <= EMIT;
        end
        EMIT: begin
          push_r   <= 1'b1;
          push_dat <= dec.unk ? ASCII_Q : dec.ch;
          err      <= dec.unk;
          len      <= '0;
          pat      <= '0;
          // a press landing on the emit cycle must not be lost
          state    <= press ? MARK : GAP;
        end
        GAP: begin
          if (press) begin
            state <= MARK;
          end else if (cnt == T_WORD) begin
            push_r   <= 1'b1;
            push_dat <= ASCII_SP;
            state    <= IDLE;
          end
        end
        ERRW: begin
          // rel guard: cnt in the release cycle is the old mark length
          if (!key && !rel && cnt == T_CHAR) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_data  <= '0;
      char_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (push_r) begin
        if (!char_valid || char_ready) begin
          char_data  <= push_dat;
          char_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (char_valid && char_ready) begin
        char_valid <= 1'b0;
      end
    end
  end

`ifdef MORSE_RX_ECHO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_echo_n <= 1'b1;
    else     led_echo_n <= ~key;
  end
`endif

endmodule

// File: tb/tb_morse_rx.sv
module tb_morse_rx;
  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       err;
  logic       overrun;
`ifdef MORSE_RX_ECHO_EN
  logic       led_echo_n;
`endif

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int base;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  morse_rx #(.DOT_CYCLES(10), .DEBOUNCE_CYCLES(2), .MAX_SYMBOLS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .err        (err),
    .overrun    (overrun)
`ifdef MORSE_RX_ECHO_EN
    ,
    .led_echo_n (led_echo_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every handshake pops one expected character
  always @(negedge clk) begin
    if (!rst) begin
      if (err)     err_cnt++;
      if (overrun) ovr_cnt++;
      if (char_valid && char_ready) begin
        chk("char_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("char_data", int'(char_data), int'(e));
        end
      end
    end
  end

  task automatic hold(input logic lvl, input int n);
    key_n = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // '.' = 1-unit press, '-' = 3-unit press, 1-unit gaps, 3-unit gap after the letter
  task automatic letter(input string s);
    for (int i = 0; i < s.len(); i++) begin
      hold(1'b0, (s[i] == "-") ? 30 : 10);
      hold(1'b1, 10);
    end
    hold(1'b1, 20);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk({"drain_", tag}, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; key_n = 1'b1; char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_data", int'(char_data), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    hold(1'b1, 5);

    // SOS then word gap
    exp_q.push_back(8'h53); exp_q.push_back(8'h4F);
    exp_q.push_back(8'h53); exp_q.push_back(8'h20);
    letter("..."); letter("---"); letter("...");
    hold(1'b1, 40);
    drain("sos");
    chk("sos_err", err_cnt, 0);

    // char-gap boundary: 19 cycles joins, 20 cycles splits
    exp_q.push_back(8'h49); exp_q.push_back(8'h20);
    hold(1'b0, 10); hold(1'b1, 19); hold(1'b0, 10); hold(1'b1, 60);
    drain("gap19");
    exp_q.push_back(8'h45); exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    hold(1'b0, 10); hold(1'b1, 20); hold(1'b0, 10); hold(1'b1, 60);
    drain("gap20");

    // symbol overflow: 7 dots -> error, nothing pushed, then T recovers
    base = err_cnt;
    for (int i = 0; i < 7; i++) begin
      hold(1'b0, 10); hold(1'b1, 10);
    end
    hold(1'b1, 30);
    chk("ovf_err", err_cnt - base, 1);
    chk("ovf_nochar", int'(char_valid), 0);
    exp_q.push_back(8'h54); exp_q.push_back(8'h20);
    letter("-");
    hold(1'b1, 40);
    drain("ovf_t");
    chk("ovf_t_err", err_cnt - base, 1);

    // unknown pattern ..--
    base = err_cnt;
    exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
    letter("..--");
    hold(1'b1, 40);
    drain("unk");
    chk("unk_err", err_cnt - base, 1);

    // backpressure: E held, T dropped with overrun
    base = ovr_cnt;
    char_ready = 1'b0;
    letter(".");
    letter("-");
    chk("bp_valid", int'(char_valid), 1);
    chk("bp_data", int'(char_data), 8'h45);
    chk("bp_overrun", ovr_cnt - base, 1);
    exp_q.push_back(8'h45);
    char_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", int'(char_valid), 0);
    chk("bp_data_hold", int'(char_data), 8'h45);
    exp_q.push_back(8'h20);
    hold(1'b1, 40);
    drain("bp");

    // async reset in the middle of a mark
    base = err_cnt;
    hold(1'b0, 30);
    rst = 1'b1;
    #1;
    chk("mrst_valid", int'(char_valid), 0);
    chk("mrst_data", int'(char_data), 0);
    chk("mrst_err", int'(err), 0);
    chk("mrst_overrun", int'(overrun), 0);
    key_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 100);
    chk("mrst_nochar", int'(char_valid), 0);
    chk("mrst_noerr", err_cnt - base, 0);
    drain("mrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
